ae_frame_rx: RTL

//  Upstream framing stage for the FC autoencoder layer: receives the raw UART byte stream, hunts a sync byte,

---
 rtl/ae_frame_rx_if.sv | 22 ++
 rtl/ae_frame_rx.sv | 99 +++++++++
 2 files changed

// File: rtl/ae_frame_rx_if.sv
// Byte-stream side and FC-layer side of the frame receiver, bundled as one interface.
interface ae_frame_rx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              rx_data_valid;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] out_dat;
    logic              out_valid;
    logic              busy;
    logic              frame_ok;
    logic              frame_err;

    modport master (
        output rx_data_valid, rx_data,
        input  out_dat, out_valid, busy, frame_ok, frame_err
    );

    modport slave (
        input  rx_data_valid, rx_data,
        output out_dat, out_valid, busy, frame_ok, frame_err
    );
endinterface

// File: rtl/ae_frame_rx.sv
// Sync-hunting frame receiver: buffers one payload, verifies an 8-bit additive checksum and
// replays the payload to the FC layer as back-to-back valid beats only when it matches.
module ae_frame_rx #(
    parameter int unsigned       DIM_INPUT   = 96,
    parameter int unsigned       DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = 8'hA5,
    parameter int unsigned       TIMEOUT_CYC = 174000
) (
    input logic          clk,
    input logic          rst_n,
    ae_frame_rx_if.slave bus
);
    localparam int unsigned       CNT_W    = $clog2(DIM_INPUT + 1);
    localparam int unsigned       GAP_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DIM_INPUT - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StPayload, StCheck, StPlay} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [CNT_W-1:0]  rd_ptr_q;
    logic [GAP_W-1:0]  gap_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] frame_buf [DIM_INPUT];
    logic              wr_en;

    assign wr_en    = (state_q == StPayload) && bus.rx_data_valid;
    assign bus.busy = (state_q != StIdle);

    // Buffer has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_buf[byte_cnt_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            byte_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            gap_q         <= '0;
            sum_q         <= '0;
            bus.out_dat   <= '0;
            bus.out_valid <= 1'b0;
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_data_valid && (bus.rx_data == SYNC_BYTE)) begin
                        state_q    <= StPayload;
                        byte_cnt_q <= '0;
                        sum_q      <= '0;
                        gap_q      <= '0;
                    end
                end
                StPayload, StCheck: begin
                    if (bus.rx_data_valid) begin
                        gap_q <= '0;
                        if (state_q == StPayload) begin
                            sum_q      <= sum_q + bus.rx_data;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            if (byte_cnt_q == LAST_IDX) begin
                                state_q <= StCheck;
                            end
                        end else if (bus.rx_data == sum_q) begin
                            bus.frame_ok <= 1'b1;
                            rd_ptr_q     <= '0;
                            state_q      <= StPlay;
                        end else begin
                            bus.frame_err <= 1'b1;
                            state_q       <= StIdle;
                        end
                    end else if (gap_q == GAP_MAX) begin
                        // Sender stalled mid-frame: drop the partial frame.
                        bus.frame_err <= 1'b1;
                        state_q       <= StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                StPlay: begin
                    bus.out_dat   <= frame_buf[rd_ptr_q];
                    bus.out_valid <= 1'b1;
                    rd_ptr_q      <= rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_IDX) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
